// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between a UART byte stream and a CPU read port.
// First-word fall-through register array with sticky overrun and synchronous flush.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [WIDTH-1:0]         DataIn,
    input  logic                     DataInValid,
    output logic                     DataInReady,
    output logic [WIDTH-1:0]         DataOut,
    output logic                     DataOutValid,
    input  logic                     DataOutReady,
    input  logic                     Clear,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             push, pop;

    // Full blocks writes outright, even when a pop happens in the same cycle.
    assign DataInReady  = (count_q != FULL_COUNT);
    assign DataOutValid = (count_q != '0);
    assign push         = DataInValid & DataInReady;
    assign pop          = DataOutValid & DataOutReady;
    assign DataOut      = mem_q[rd_ptr_q];
    assign Count        = count_q;
    assign Overrun      = overrun_q;

    always_comb begin
        // NOTE: every next-state value gets a default first so no latch is inferred.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (Clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            overrun_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            if (DataInValid && (count_q == FULL_COUNT)) overrun_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: storage is deliberately not reset; Count alone decides which slots are meaningful.
    always_ff @(posedge Clock) begin
        if (push) mem_q[wr_ptr_q] <= DataIn;
    end

endmodule
